// File: rtl/tetris_step_ctrl.sv
// Game-step sequencer for the tetris move ALU: owns the falling piece, issues one
// ALU action per step, commits legal results and sequences lock / row reduction / game over.
module tetris_step_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               tick,
   input  logic               cmd_valid,
   input  logic [WIDTH-1:0]   cmd_action,
   output logic               cmd_ready,
   input  logic [WIDTH-1:0]   fig_code,
   input  logic [4*WIDTH-1:0] fig_rho_x,
   input  logic [4*WIDTH-1:0] fig_rho_y,
   output logic               fig_req,
   output logic [WIDTH-1:0]   alu_action,
   output logic [WIDTH-1:0]   alu_figure,
   output logic               alu_is_move,
   output logic               alu_is_reduce,
   output logic [4*WIDTH-1:0] alu_rho_x,
   output logic [4*WIDTH-1:0] alu_rho_y,
   input  logic [4*WIDTH-1:0] alu_new_rho_x,
   input  logic [4*WIDTH-1:0] alu_new_rho_y,
   input  logic               collide,
   output logic               lock_req,
   input  logic               lock_done,
   input  logic               full_row,
   output logic               reduce_req,
   input  logic               reduce_done,
   output logic [CNT_W-1:0]   lines,
   output logic               game_over
);

   typedef enum logic [2:0] {
      IDLE, SPAWN, READY, MOVE, LOCK, CHECKROW, REDUCE, GAME_OVER
   } state_t;

   localparam logic [WIDTH-1:0] ACT_DOWN = WIDTH'(1);
   localparam logic [WIDTH-1:0] ACT_MAX  = WIDTH'(5);

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   figure;
   logic [WIDTH-1:0]   action;
   logic [4*WIDTH-1:0] rho_x;
   logic [4*WIDTH-1:0] rho_y;
   logic               pending_tick;
   logic               want_down;
   logic               cmd_ok;

   // A tick arriving this cycle counts as pending, so it already outranks a same-cycle command.
   assign want_down = (state == READY) && (pending_tick || tick);
   assign cmd_ok    = (cmd_action != WIDTH'(0)) && (cmd_action <= ACT_MAX);

   always_comb begin
      state_next    = state;
      fig_req       = 1'b0;
      cmd_ready     = 1'b0;
      game_over     = 1'b0;
      alu_is_move   = 1'b0;
      alu_is_reduce = 1'b0;
      alu_action    = '0;
      alu_figure    = figure;
      alu_rho_x     = rho_x;
      alu_rho_y     = rho_y;
      case (state)
         IDLE: begin
            if (start) state_next = SPAWN;
            else       state_next = IDLE;
         end
         SPAWN: begin
            alu_is_move = 1'b1;
            alu_figure  = fig_code;
            alu_rho_x   = fig_rho_x;
            alu_rho_y   = fig_rho_y;
            fig_req     = 1'b1;
            if (collide) state_next = GAME_OVER;
            else         state_next = READY;
         end
         READY: begin
            cmd_ready = !(pending_tick || tick);
            if (want_down)                   state_next = MOVE;
            else if (cmd_valid && cmd_ok)    state_next = MOVE;
            else                             state_next = READY;
         end
         MOVE: begin
            alu_is_move = 1'b1;
            alu_action  = action;
            if (collide && (action == ACT_DOWN)) state_next = LOCK;
            else                                 state_next = READY;
         end
         LOCK: begin
            if (lock_done) state_next = CHECKROW;
            else           state_next = LOCK;
         end
         CHECKROW: begin
            if (full_row) state_next = REDUCE;
            else          state_next = SPAWN;
         end
         REDUCE: begin
            alu_is_reduce = 1'b1;
            if (reduce_done) state_next = CHECKROW;
            else             state_next = REDUCE;
         end
         GAME_OVER: begin
            game_over = 1'b1;
            if (start) state_next = SPAWN;
            else       state_next = GAME_OVER;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         figure       <= '0;
         action       <= '0;
         rho_x        <= '0;
         rho_y        <= '0;
         pending_tick <= 1'b0;
         lines        <= '0;
         lock_req     <= 1'b0;
         reduce_req   <= 1'b0;
      end else begin
         state      <= state_next;
         lock_req   <= (state_next == LOCK)   && (state != LOCK);
         reduce_req <= (state_next == REDUCE) && (state != REDUCE);
         case (state)
            IDLE, GAME_OVER: begin
               pending_tick <= 1'b0;
               if (start) lines <= '0;
            end
            SPAWN: begin
               pending_tick <= pending_tick | tick;
               if (!collide) begin
                  figure <= fig_code;
                  rho_x  <= alu_new_rho_x;
                  rho_y  <= alu_new_rho_y;
               end
            end
            READY: begin
               // one request is consumed; a second one arriving alongside stays queued
               pending_tick <= pending_tick & tick;
               if (want_down)      action <= ACT_DOWN;
               else if (cmd_valid) action <= cmd_action;
            end
            MOVE: begin
               pending_tick <= pending_tick | tick;
               if (!collide) begin
                  rho_x <= alu_new_rho_x;
                  rho_y <= alu_new_rho_y;
               end
            end
            REDUCE: begin
               pending_tick <= pending_tick | tick;
               if (reduce_done && (lines != {CNT_W{1'b1}})) lines <= lines + CNT_W'(1);
            end
            default: pending_tick <= pending_tick | tick;
         endcase
      end
   end

endmodule

// File: doc/tetris_step_ctrl.md
Name: tetris_step_ctrl

Overview:
- Game-step sequencer for the tetris move ALU. Owns the falling piece state: figure code, rho_x, rho_y.
- Each cycle it issues at most one ALU action: load, down, left, right, rotR or rotL. It commits the ALU result only if the external collision checker reports the new coordinates legal.
- It also sequences piece locking, full-row reduction and game-over.
- Sits between the input/gravity front-end and the ALU, the collision checker and the board writer.

Parameters:
WIDTH, 8, coordinate and action/figure code width
CNT_W, 16, width of the lines-cleared counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; leaves IDLE or GAME_OVER and starts a game
tick  in  1  gravity pulse; one down request
cmd_valid  in  1  user command valid
cmd_action  in  WIDTH  user action code, 1..5 (down/left/right/rotR/rotL)
cmd_ready  out  1  command accepted this cycle when cmd_valid&cmd_ready
fig_code  in  WIDTH  next figure from the generator
fig_rho_x  in  4*WIDTH  spawn x coordinates of the next figure
fig_rho_y  in  4*WIDTH  spawn y coordinates of the next figure
fig_req  out  1  one-cycle pulse; generator advances after SPAWN
alu_action  out  WIDTH  ALU action code
alu_figure  out  WIDTH  current figure code
alu_is_move  out  1  ALU move enable
alu_is_reduce  out  1  ALU reduce enable
alu_rho_x  out  4*WIDTH  current/candidate x to ALU
alu_rho_y  out  4*WIDTH  current/candidate y to ALU
alu_new_rho_x  in  4*WIDTH  ALU result x (combinational)
alu_new_rho_y  in  4*WIDTH  ALU result y (combinational)
collide  in  1  combinational checker verdict on alu_new_rho_*, same cycle
lock_req  out  1  pulse; board writer stamps piece at rho_x/rho_y
lock_done  in  1  pulse; stamp finished
full_row  in  1  board has at least one full row (valid in CHECKROW)
reduce_req  out  1  pulse; board removes lowest full row
reduce_done  in  1  pulse; one row removed
lines  out  CNT_W  rows cleared this game, saturating
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset: state=IDLE. rho_x/rho_y/figure=0, lines=0, pending_tick=0. All out pulses/enables 0. alu_action=0, cmd_ready=0, game_over=0.
- Reset mid-operation aborts any state in the same edge, including outstanding lock/reduce. Late lock_done/reduce_done are ignored in IDLE.
- States: IDLE, SPAWN, READY, MOVE, LOCK, CHECKROW, REDUCE, GAME_OVER.
- IDLE: start -> SPAWN, lines=0.
- SPAWN (1 cycle):
  - Drives alu_is_move=1, action 0, alu_figure=fig_code, alu_rho_*=fig_rho_*. fig_req=1.
  - !collide: latch figure=fig_code, rho_*=alu_new_rho_*, go to READY.
  - collide: go to GAME_OVER; rho is not updated.
- READY:
  - cmd_ready=1 iff pending_tick=0.
  - tick in any non-IDLE/non-GAME_OVER state sets pending_tick. tick in the same cycle as a consumed pending_tick keeps it set.
  - Selection priority: pending_tick, then down(1); else accepted command. Both present: tick wins; the command is not accepted and stays held by the front-end.
  - Selected action is registered; go to MOVE. Invalid codes (0 or >5) are accepted and dropped, and the state stays READY.
- MOVE (1 cycle):
  - alu_is_move=1, alu_action=registered action, alu_rho_*=rho_*.
  - !collide: commit alu_new_rho_* to rho_*, go to READY.
  - collide and action==down: go to LOCK.
  - collide otherwise: discard, go to READY.
- Command-to-commit latency is 2 cycles: accept edge, then MOVE edge.
- LOCK: lock_req pulses on entry only; wait for lock_done, then go to CHECKROW.
- CHECKROW: full_row=1 -> REDUCE; else -> SPAWN.
- REDUCE: reduce_req pulse on entry; alu_is_reduce=1 while here (ALU result ignored). On reduce_done: lines+1, saturating at all-ones, then go to CHECKROW.
- GAME_OVER: game_over=1, cmd_ready=0, ticks ignored. start -> SPAWN and clears lines.
- alu_is_move and alu_is_reduce are never both 1. Outside SPAWN/MOVE, alu_is_move=0 and alu_rho_*=rho_*.

Test Plan:
- Reset, start, fig_code=0, spawn x={3,4,5,6}, y=0, collide=0 -> fig_req one pulse; READY on cycle 2; rho_y=0.
- READY, cmd left(2), collide=0 -> rho_x={2,3,4,5} two cycles after accept; cmd_ready low during MOVE.
- tick and cmd right in same cycle -> down executed first (rho_y+1); right accepted the following READY cycle.
- down with collide=1 -> lock_req one pulse; lock_done, full_row=1 twice -> two reduce_req; lines=2; then SPAWN.
- SPAWN with collide=1 -> game_over=1, cmd_ready=0; ticks ignored; start -> SPAWN, lines=0.
- Reset asserted in REDUCE before reduce_done -> next cycle IDLE, all outputs 0; later reduce_done has no effect.
